// File: rtl/seq_alu.sv
// Multi-cycle ALU with a start/busy/done handshake.
// MUL (shift-add) and SRL (1 bit per cycle) iterate; all other ops finish one cycle after acceptance.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             overflow
);

  localparam int SW = $clog2(WIDTH);
  localparam int M  = WIDTH - 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;      // operand A, shifted multiplicand, or value being shifted
  logic [WIDTH-1:0] b_q;      // operand B, or multiplier consumed LSB first
  logic [WIDTH-1:0] acc;
  logic [SW-1:0]    cnt;

  logic [WIDTH-1:0] sum, diff, acc_nxt, step_res;
  logic             ovf_add, ovf_sub, step_ovf;
  logic [SW-1:0]    shamt_in;

  assign shamt_in = B[SW-1:0];

  always_comb begin
    sum      = a_q + b_q;
    diff     = a_q - b_q;
    ovf_add  = (a_q[M] == b_q[M]) && (sum[M] != a_q[M]);
    ovf_sub  = (a_q[M] != b_q[M]) && (diff[M] != a_q[M]);
    acc_nxt  = b_q[0] ? (acc + a_q) : acc;
    step_res = '0;
    step_ovf = 1'b0;
    case (op_q)
      OP_AND: step_res = a_q & b_q;
      OP_OR:  step_res = a_q | b_q;
      OP_ADD: begin step_res = sum;  step_ovf = ovf_add; end
      OP_MUL: step_res = acc_nxt;
      OP_NOR: step_res = ~(a_q | b_q);
      // b_q is left untouched for SRL, so a zero shift amount is still visible here
      OP_SRL: step_res = (b_q[SW-1:0] == '0) ? a_q : (a_q >> 1);
      OP_SUB: begin step_res = diff; step_ovf = ovf_sub; end
      OP_SLT: step_res = {{(WIDTH-1){1'b0}}, diff[M] ^ ovf_sub};
      default: step_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      res      <= '0;
      zero     <= 1'b1;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op;
            a_q   <= A;
            b_q   <= B;
            acc   <= '0;
            busy  <= 1'b1;
            state <= RUN;
            if (op == OP_MUL)
              cnt <= SW'(WIDTH - 1);
            else if (op == OP_SRL && shamt_in != '0)
              cnt <= shamt_in - 1'b1;
            else
              cnt <= '0;
          end
        end
        RUN: begin
          if (cnt == '0) begin
            res      <= step_res;
            zero     <= (step_res == '0);
            overflow <= step_ovf;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
            if (op_q == OP_MUL) begin
              acc <= acc_nxt;
              a_q <= a_q << 1;
              b_q <= b_q >> 1;
            end else if (op_q == OP_SRL) begin
              a_q <= a_q >> 1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
